// File: rtl/dmem_io_arbiter.sv
// rtl/dmem_io_arbiter.sv - two-port round-robin arbiter/sequencer for DataMemory and memory-mapped I/O
//
// Purpose: grants one of two requesters (port 0 CPU, port 1 debug/DMA), decodes
// the captured address to DataMemory or the I/O register block, drives the
// target strobes and returns read data with a one-cycle valid pulse.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-low reset
//   req_i, wr_i             per-port request and write flag
//   addr_i, wdata_i         per-port byte address / write data, port p in [p*DBITS +: DBITS]
//   gnt_o, rvalid_o         one-hot accept pulse / read-response pulse
//   rdata_o                 read data, nonzero only with rvalid_o
//   dmem_addr_o, dmem_wrt_en_o, dmem_wdata_o, dmem_rdata_i   DataMemory side
//   io_sel_o {SW,KEY,LEDG,LEDR,HEX}, io_wr_en_o, io_rd_en_o, io_wdata_o, io_rdata_i   I/O side
//   busy_o                  high whenever the sequencer is not idle
module dmem_io_arbiter #(
  parameter int DBITS               = 32,
  parameter int DMEM_ADDR_BIT_WIDTH = 11,
  parameter int IO_WAIT_CYCLES      = 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [1:0]                     req_i,
  input  logic [1:0]                     wr_i,
  input  logic [2*DBITS-1:0]             addr_i,
  input  logic [2*DBITS-1:0]             wdata_i,
  output logic [1:0]                     gnt_o,
  output logic [1:0]                     rvalid_o,
  output logic [DBITS-1:0]               rdata_o,
  output logic [DMEM_ADDR_BIT_WIDTH-1:0] dmem_addr_o,
  output logic                           dmem_wrt_en_o,
  output logic [DBITS-1:0]               dmem_wdata_o,
  input  logic [DBITS-1:0]               dmem_rdata_i,
  output logic [4:0]                     io_sel_o,
  output logic                           io_wr_en_o,
  output logic                           io_rd_en_o,
  output logic [DBITS-1:0]               io_wdata_o,
  input  logic [DBITS-1:0]               io_rdata_i,
  output logic                           busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_IO_WAIT, S_RESP} state_e;

  localparam logic [3:0] CNT_INIT = 4'(IO_WAIT_CYCLES);

  state_e           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic             win_q, win_d;
  logic             wr_q, wr_d;
  logic [DBITS-1:0] addr_q, addr_d;
  logic [DBITS-1:0] wdata_q, wdata_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [DBITS-1:0] iodat_q, iodat_d;

  logic             pick;
  logic             is_io;
  logic [4:0]       io_dec;
  logic             io_wr_ok, io_rd_ok;
  logic             unused_addr;

  assign unused_addr = ^addr_q;

  // Single requester wins outright; on contention the port not served last wins.
  always_comb begin
    pick = ~rr_last_q;
    if (req_i == 2'b01) pick = 1'b0;
    else if (req_i == 2'b10) pick = 1'b1;
  end

  assign is_io = (addr_q[DBITS-1 -: 4] == 4'hF);

  always_comb begin
    io_dec = 5'b00000;
    if (is_io) begin
      case (addr_q[7:0])
        8'h00:   io_dec = 5'b00001;
        8'h04:   io_dec = 5'b00010;
        8'h08:   io_dec = 5'b00100;
        8'h10:   io_dec = 5'b01000;
        8'h14:   io_dec = 5'b10000;
        default: io_dec = 5'b00000;
      endcase
    end
  end

  // HEX/LEDR/LEDG are write-only, KEY/SW read-only; anything else gets no strobe.
  assign io_wr_ok = |io_dec[2:0];
  assign io_rd_ok = |io_dec[4:3];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      rr_last_q <= 1'b1;
      win_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      iodat_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      win_q     <= win_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      iodat_q   <= iodat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    win_d     = win_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    // The register block output follows io_sel, which drops in RESP, so keep
    // the value from the last cycle the read strobe was high.
    iodat_d   = io_rd_en_o ? io_rdata_i : iodat_q;
    case (state_q)
      S_IDLE: begin
        if (req_i != 2'b00) begin
          win_d     = pick;
          rr_last_d = pick;
          wr_d      = pick ? wr_i[1] : wr_i[0];
          addr_d    = pick ? addr_i[2*DBITS-1:DBITS] : addr_i[DBITS-1:0];
          wdata_d   = pick ? wdata_i[2*DBITS-1:DBITS] : wdata_i[DBITS-1:0];
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = CNT_INIT;
        if (wr_q) state_d = S_IDLE;
        else if (is_io && io_rd_ok && (IO_WAIT_CYCLES != 0)) state_d = S_IO_WAIT;
        else state_d = S_RESP;
      end
      S_IO_WAIT: begin
        if (cnt_q <= 4'd1) state_d = S_RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o         = 2'b00;
    rvalid_o      = 2'b00;
    rdata_o       = '0;
    dmem_addr_o   = '0;
    dmem_wrt_en_o = 1'b0;
    dmem_wdata_o  = '0;
    io_sel_o      = 5'b00000;
    io_wr_en_o    = 1'b0;
    io_rd_en_o    = 1'b0;
    io_wdata_o    = '0;
    busy_o        = (state_q != S_IDLE);
    case (state_q)
      S_ACCESS: begin
        gnt_o = win_q ? 2'b10 : 2'b01;
        if (!is_io) begin
          dmem_addr_o = addr_q[DMEM_ADDR_BIT_WIDTH+1:2];
          if (wr_q) begin
            dmem_wrt_en_o = 1'b1;
            dmem_wdata_o  = wdata_q;
          end
        end else if (wr_q && io_wr_ok) begin
          io_wr_en_o = 1'b1;
          io_sel_o   = io_dec;
          io_wdata_o = wdata_q;
        end else if (!wr_q && io_rd_ok) begin
          io_rd_en_o = 1'b1;
          io_sel_o   = io_dec;
        end
      end
      S_IO_WAIT: begin
        io_rd_en_o = 1'b1;
        io_sel_o   = io_dec;
      end
      S_RESP: begin
        rvalid_o = win_q ? 2'b10 : 2'b01;
        if (!is_io) rdata_o = dmem_rdata_i;
        else if (io_rd_ok) rdata_o = iodat_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_io_arbiter.sv
// tb/tb_dmem_io_arbiter.sv - scoreboard testbench for dmem_io_arbiter
module tb_dmem_io_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [1:0]  req_i, wr_i;
  logic [63:0] addr_i, wdata_i;
  logic [1:0]  gnt_o, rvalid_o;
  logic [31:0] rdata_o;
  logic [10:0] dmem_addr_o;
  logic        dmem_wrt_en_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic [4:0]  io_sel_o;
  logic        io_wr_en_o, io_rd_en_o;
  logic [31:0] io_wdata_o, io_rdata_i;
  logic        busy_o;

  dmem_io_arbiter #(.DBITS(32), .DMEM_ADDR_BIT_WIDTH(11), .IO_WAIT_CYCLES(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wrt_en_o(dmem_wrt_en_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata_i), .io_sel_o(io_sel_o), .io_wr_en_o(io_wr_en_o),
    .io_rd_en_o(io_rd_en_o), .io_wdata_o(io_wdata_o), .io_rdata_i(io_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous DataMemory model: write on the edge, read data valid next cycle.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (dmem_wrt_en_o) mem[dmem_addr_o] <= dmem_wdata_o;
    dmem_rdata_i <= mem[dmem_addr_o];
  end

  // I/O register block: SW=0x2A5, KEY=0x5; unselected reads return garbage.
  assign io_rdata_i = io_sel_o[4] ? 32'h0000_02A5 :
                      io_sel_o[3] ? 32'h0000_0005 : 32'hBAD0_0000;

  int          io_wr_cnt = 0;
  logic [31:0] io_last_wd = '0;
  logic [4:0]  io_last_sel = '0;
  always @(posedge clk) begin
    if (io_wr_en_o) begin
      io_wr_cnt   <= io_wr_cnt + 1;
      io_last_wd  <= io_wdata_o;
      io_last_sel <= io_sel_o;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  gnt;
    logic        wen;
    logic [10:0] daddr;
    logic [4:0]  sel;
    logic        iowen;
    logic        iorden;
    logic [31:0] dwd;
    logic [31:0] iwd;
    int          gap;
  } acc_t;

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] data;
    int          lat;
  } resp_t;

  acc_t  exp_acc[$];
  resp_t exp_resp[$];

  task automatic push_acc(input logic [1:0] g, input logic wen, input logic [10:0] da,
                          input logic [4:0] sel, input logic iowen, input logic iorden,
                          input logic [31:0] dwd, input logic [31:0] iwd, input int gap);
    acc_t a;
    a.gnt = g; a.wen = wen; a.daddr = da; a.sel = sel; a.iowen = iowen;
    a.iorden = iorden; a.dwd = dwd; a.iwd = iwd; a.gap = gap;
    exp_acc.push_back(a);
  endtask

  task automatic push_resp(input logic [1:0] rv, input logic [31:0] d, input int lat);
    resp_t r;
    r.rv = rv; r.data = d; r.lat = lat;
    exp_resp.push_back(r);
  endtask

  // Monitor: compares every grant and every read response against the queues.
  int last_gnt = -1000;
  int rden_cnt = 0;
  acc_t  ma;
  resp_t mr;
  always @(negedge clk) begin
    if (gnt_o != 2'b00) begin
      if (exp_acc.size() == 0) begin
        check("gnt_unexpected", 64'(gnt_o), 64'd0);
      end else begin
        ma = exp_acc.pop_front();
        check("gnt", 64'(gnt_o), 64'(ma.gnt));
        check("dmem_wrt_en", 64'(dmem_wrt_en_o), 64'(ma.wen));
        check("dmem_addr", 64'(dmem_addr_o), 64'(ma.daddr));
        check("dmem_wdata", 64'(dmem_wdata_o), 64'(ma.dwd));
        check("io_sel", 64'(io_sel_o), 64'(ma.sel));
        check("io_wr_en", 64'(io_wr_en_o), 64'(ma.iowen));
        check("io_rd_en", 64'(io_rd_en_o), 64'(ma.iorden));
        check("io_wdata", 64'(io_wdata_o), 64'(ma.iwd));
        if (ma.gap >= 0) check("gnt_gap", 64'(cyc - last_gnt), 64'(ma.gap));
      end
      last_gnt = cyc;
      rden_cnt = 0;
    end
    if (io_rd_en_o) rden_cnt++;
    if (rvalid_o != 2'b00) begin
      if (exp_resp.size() == 0) begin
        check("rvalid_unexpected", 64'(rvalid_o), 64'd0);
      end else begin
        mr = exp_resp.pop_front();
        check("rvalid", 64'(rvalid_o), 64'(mr.rv));
        check("rdata", 64'(rdata_o), 64'(mr.data));
        check("resp_latency", 64'(cyc - last_gnt), 64'(mr.lat));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(n < 20), 64'd1);
  endtask

  task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    req_i[p] = 1'b1;
    wr_i[p] = w;
    if (p == 0) begin addr_i[31:0] = a; wdata_i[31:0] = d; end
    else begin addr_i[63:32] = a; wdata_i[63:32] = d; end
    while (!gnt_o[p] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("gnt_timeout", 64'(n < 20), 64'd1);
    req_i[p] = 1'b0;
    wait_idle();
  endtask

  task automatic pair(input logic [1:0] w, input logic [31:0] a0, input logic [31:0] d0,
                      input logic [31:0] a1, input logic [31:0] d1, input int ngnt,
                      input bit drop_each);
    int n = 0;
    int got = 0;
    @(negedge clk);
    wr_i = w;
    addr_i = {a1, a0};
    wdata_i = {d1, d0};
    req_i = 2'b11;
    while (got < ngnt && n < 40) begin
      @(negedge clk);
      n++;
      if (gnt_o != 2'b00) begin
        got++;
        if (drop_each) req_i = req_i & ~gnt_o;
      end
    end
    req_i = 2'b00;
    check("pair_timeout", 64'(got), 64'(ngnt));
    wait_idle();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    reset_i = 1'b0;
    req_i = 2'b00; wr_i = 2'b00; addr_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(|{gnt_o, rvalid_o, rdata_o, dmem_addr_o, dmem_wrt_en_o,
          dmem_wdata_o, io_sel_o, io_wr_en_o, io_rd_en_o, io_wdata_o, busy_o}), 64'd0);
    reset_i = 1'b1;

    // T1: DataMemory write by port 0, read back by port 1
    push_acc(2'b01, 1'b1, 11'h040, 5'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, -1);
    issue(0, 1'b1, 32'h0000_0100, 32'hDEADBEEF);
    push_acc(2'b10, 1'b0, 11'h040, 5'b0, 1'b0, 1'b0, 32'h0, 32'h0, -1);
    push_resp(2'b10, 32'hDEADBEEF, 1);
    issue(1, 1'b0, 32'h0000_0100, 32'h0);

    // Preload words 0 and 1 through port 1 so the next winner order stays 01 first
    push_acc(2'b10, 1'b1, 11'h000, 5'b0, 1'b0, 1'b0, 32'h1111_1111, 32'h0, -1);
    issue(1, 1'b1, 32'h0000_0000, 32'h1111_1111);
    push_acc(2'b10, 1'b1, 11'h001, 5'b0, 1'b0, 1'b0, 32'h2222_2222, 32'h0, -1);
    issue(1, 1'b1, 32'h0000_0004, 32'h2222_2222);

    // T2: both ports hold read requests; grants alternate every 3 cycles
    push_acc(2'b01, 1'b0, 11'h000, 5'b0, 1'b0, 1'b0, 32'h0, 32'h0, -1);
    push_resp(2'b01, 32'h1111_1111, 1);
    push_acc(2'b10, 1'b0, 11'h001, 5'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3);
    push_resp(2'b10, 32'h2222_2222, 1);
    push_acc(2'b01, 1'b0, 11'h000, 5'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3);
    push_resp(2'b01, 32'h1111_1111, 1);
    push_acc(2'b10, 1'b0, 11'h001, 5'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3);
    push_resp(2'b10, 32'h2222_2222, 1);
    pair(2'b00, 32'h0, 32'h0, 32'h4, 32'h0, 4, 1'b0);

    // T3: SW read with two wait cycles
    push_acc(2'b01, 1'b0, 11'h000, 5'b10000, 1'b0, 1'b1, 32'h0, 32'h0, -1);
    push_resp(2'b01, 32'h0000_02A5, 3);
    issue(0, 1'b0, 32'hF000_0014, 32'h0);
    check("io_rd_en_cycles", 64'(rden_cnt), 64'd3);

    // T4: HEX write, then write to read-only SW
    push_acc(2'b01, 1'b0, 11'h000, 5'b00001, 1'b1, 1'b0, 32'h0, 32'h1234, -1);
    issue(0, 1'b1, 32'hF000_0000, 32'h1234);
    check("io_write_count", 64'(io_wr_cnt), 64'd1);
    check("io_write_data", 64'(io_last_wd), 64'h1234);
    check("io_write_sel", 64'(io_last_sel), 64'b00001);
    push_acc(2'b01, 1'b0, 11'h000, 5'b0, 1'b0, 1'b0, 32'h0, 32'h0, -1);
    issue(0, 1'b1, 32'hF000_0014, 32'h5);
    check("io_write_count_ro", 64'(io_wr_cnt), 64'd1);

    // T5: unmapped I/O read, DataMemory write/read of word 2, KEY read
    push_acc(2'b01, 1'b0, 11'h000, 5'b0, 1'b0, 1'b0, 32'h0, 32'h0, -1);
    push_resp(2'b01, 32'h0, 1);
    issue(0, 1'b0, 32'hF000_000C, 32'h0);
    push_acc(2'b10, 1'b1, 11'h002, 5'b0, 1'b0, 1'b0, 32'h7, 32'h0, -1);
    issue(1, 1'b1, 32'h0000_0008, 32'h7);
    push_acc(2'b01, 1'b0, 11'h002, 5'b0, 1'b0, 1'b0, 32'h0, 32'h0, -1);
    push_resp(2'b01, 32'h7, 1);
    issue(0, 1'b0, 32'h0000_0008, 32'h0);
    push_acc(2'b10, 1'b0, 11'h000, 5'b01000, 1'b0, 1'b1, 32'h0, 32'h0, -1);
    push_resp(2'b10, 32'h5, 3);
    issue(1, 1'b0, 32'hF000_0010, 32'h0);

    // T6: asynchronous reset in the middle of IO_WAIT
    push_acc(2'b01, 1'b0, 11'h000, 5'b10000, 1'b0, 1'b1, 32'h0, 32'h0, -1);
    @(negedge clk);
    req_i[0] = 1'b1; wr_i[0] = 1'b0; addr_i[31:0] = 32'hF000_0014;
    n = 0;
    while (!gnt_o[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_gnt_timeout", 64'(n < 20), 64'd1);
    req_i[0] = 1'b0;
    @(posedge clk);
    #2;
    check("t6_in_wait", 64'({busy_o, io_rd_en_o}), 64'b11);
    reset_i = 1'b0;
    #1;
    check("t6_async_outputs", 64'(|{gnt_o, rvalid_o, rdata_o, dmem_addr_o, dmem_wrt_en_o,
          dmem_wdata_o, io_sel_o, io_wr_en_o, io_rd_en_o, io_wdata_o, busy_o}), 64'd0);
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_idle_after", 64'(busy_o), 64'd0);
    push_acc(2'b01, 1'b1, 11'h004, 5'b0, 1'b0, 1'b0, 32'h9, 32'h0, -1);
    push_acc(2'b10, 1'b1, 11'h005, 5'b0, 1'b0, 1'b0, 32'hA, 32'h0, 2);
    pair(2'b11, 32'h0000_0010, 32'h9, 32'h0000_0014, 32'hA, 2, 1'b1);

    repeat (5) @(negedge clk);
    check("acc_queue_drained", 64'(exp_acc.size()), 64'd0);
    check("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
